mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Load/store initiator that drives port B of the dual-port data RAM on behalf of the
//   RV32IM execute stage. Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and
//   converts byte addresses to RAM word addresses. Sub-word stores use read-modify-write,
//   because the RAM has no byte enables. Returns sign-/zero-extended load data and a
//   misalignment error.
// PARAMETERS
//   ADDR_WIDTH  10  RAM word-address width (RAM holds 2**ADDR_WIDTH 32-bit words)
// PORTS
//   clk             in   1           rising-edge clock
//   rst_n           in   1           asynchronous active-low reset
//   req_valid_i     in   1           request present
//   req_ready_o     out  1           unit idle; request accepted when valid&ready
//   req_we_i        in   1           1 = store, 0 = load
//   req_size_i      in   2           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i  in   1           loads: 1 = zero-extend, 0 = sign-extend
//   req_addr_i      in   32          byte address
//   req_wdata_i     in   32          store data (LSBs used for byte/half)
//   rsp_valid_o     out  1           one-cycle response pulse
//   rsp_rdata_o     out  32          load result (0 for stores/errors)
//   rsp_err_o       out  1           misaligned or illegal size; valid with rsp_valid_o
//   ram_addr_o      out  ADDR_WIDTH  word address (req_addr_i[ADDR_WIDTH+1:2])
//   ram_wdata_o     out  32          write word
//   ram_read_en_o   out  1           read strobe, port B
//   ram_write_en_o  out  1           write strobe
//   ram_rdata_i     in   32          RAM port-B read data
//   ram_valid_i     in   1           RAM read-data valid (1 cycle after read strobe)
// BEHAVIOUR
//   - States: IDLE, RD, WAIT, WR, RESP. All outputs decode from registered state/regs.
//   - Reset (async, rst_n=0): state=IDLE; rsp_valid_o, rsp_err_o, ram_read_en_o,
//     ram_write_en_o=0; rsp_rdata_o, ram_addr_o, ram_wdata_o=0; req_ready_o=1.
//   - req_ready_o=1 only in IDLE; req_valid_i is ignored in all other states.
//   - Acceptance registers addr, size, we, unsigned and wdata.
//   - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Go to RESP
//     with err=1 and rdata=0; RAM is never accessed.
//   - RD: ram_read_en_o=1 for exactly one cycle -> WAIT.
//   - WAIT: hold until ram_valid_i=1 (no timeout); capture ram_rdata_i.
//     Load -> RESP. Sub-word store -> WR.
//   - WR: ram_write_en_o=1 for exactly one cycle -> RESP.
//   - RESP: rsp_valid_o=1 for one cycle -> IDLE. No backpressure.
//   - Paths (T = accept cycle):
//       load:            RD T+1, rsp T+3
//       SW:              WR T+1, rsp T+2
//       SB/SH:           RD T+1, WR T+3, rsp T+4
//       error:           rsp T+1
//     Each path is longer by any ram_valid_i delay.
//   - Load extract:
//       byte lane  = addr[1:0] -> data[8*lane +: 8]
//       half lane  = addr[1]   -> data[16*addr[1] +: 16]
//     Extend to 32 bits per req_unsigned_i. Word loads pass through unchanged.
//   - Store merge: replace only the addressed byte/half lane of the captured word;
//     all other bits are preserved.
//   - Address bits above ADDR_WIDTH+1 are ignored (address wraps modulo RAM size).
//   - Reset mid-operation: abandon immediately. If asserted before the WR cycle, no
//     write occurs. No response is issued.
// TESTING
//   1. SW 0xDEADBEEF @0x10, then LW @0x10:
//      ram_write_en_o high 1 cycle at T+1 with ram_addr_o=4; LW rsp at T+3 = 0xDEADBEEF.
//   2. SB 0x80 @0x11 over 0xDEADBEEF:
//      read strobe T+1, write strobe T+3, RAM word = 0xDEAD80EF.
//      Then LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080.
//   3. SH 0x1234 @0x12 -> RAM word 0x123480EF.
//      LH @0x12 -> 0x00001234; LH @0x10 -> 0xFFFF80EF; LHU @0x10 -> 0x000080EF.
//   4. LW @0x13, SH @0x11, size=11:
//      each gives rsp_err_o=1, rdata 0, rsp at T+1, no RAM strobes.
//   5. ram_valid_i delayed 5 cycles on LW:
//      unit stays in WAIT; rsp at T+8; req_valid_i pulses while busy are not accepted.
//   6. rst_n low during WAIT of SB:
//      no ram_write_en_o, no rsp_valid_o; req_ready_o=1; RAM word unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store initiator for port B of the dual-port data RAM. It takes one
//   LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and turns the byte address
//   into a RAM word address. The RAM has no byte enables, so sub-word stores
//   read the word, merge the new lane and write the word back. Loads return
//   sign- or zero-extended data. Misaligned accesses and size=11 return an
//   error and never touch the RAM.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             request handshake (valid/ready), we, size, unsigned,
//                     byte address, store data
//   rsp_*             one-cycle response pulse with load data and error flag
//   ram_*             RAM port B: word address, write word, read/write
//                     strobes, read data and read-data valid
// -----------------------------------------------------------------------------

// One byte lane of the store merge: take the new byte when this lane is
// addressed, otherwise keep the byte read back from the RAM.
module mau_lane (
   input  logic       i_wr,
   input  logic [7:0] i_old,
   input  logic [7:0] i_new,
   output logic [7:0] o_byte
);
   assign o_byte = i_wr ? i_new : i_old;
endmodule

module mem_access_unit #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [31:0]           req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   output logic                  ram_read_en_o,
   output logic                  ram_write_en_o,
   input  logic [31:0]           ram_rdata_i,
   input  logic                  ram_valid_i
);
   localparam int NUM_LANES = 4;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

   state_t                r_state, w_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_lo;      // byte offset within the word
   logic [1:0]            r_size;
   logic                  r_we;
   logic                  r_uns;
   logic [15:0]           r_wdata;   // only the low half matters for SB/SH
   logic [31:0]           r_wword;   // word presented on ram_wdata_o
   logic [31:0]           r_rdata;
   logic                  r_err;

   logic                  w_acc;
   logic                  w_misal;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_ldata;
   logic [31:0]           w_rep;
   logic [NUM_LANES-1:0]  w_lwr;
   logic [NUM_LANES-1:0][7:0] w_old, w_new, w_mrg;
   logic                  w_unused_addr;

   // Address bits above the RAM size are dropped so accesses wrap.
   assign w_unused_addr = &req_addr_i[31:ADDR_WIDTH+2];

   assign w_acc   = req_valid_i && (r_state == S_IDLE);
   assign w_misal = (req_size_i == 2'b11)
                 || ((req_size_i == 2'b01) && req_addr_i[0])
                 || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               if (w_misal)                                w_nxt = S_RESP;
               else if (req_we_i && req_size_i == 2'b10)   w_nxt = S_WR;
               else                                        w_nxt = S_RD;
            end
         end
         S_RD:   w_nxt = S_WAIT;
         S_WAIT: if (ram_valid_i) w_nxt = r_we ? S_WR : S_RESP;
         S_WR:   w_nxt = S_RESP;
         S_RESP: w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o    = (r_state == S_IDLE);
      ram_read_en_o  = (r_state == S_RD);
      ram_write_en_o = (r_state == S_WR);
      rsp_valid_o    = (r_state == S_RESP);
      rsp_err_o      = (r_state == S_RESP) && r_err;
   end

   assign ram_addr_o  = r_addr;
   assign ram_wdata_o = r_wword;
   assign rsp_rdata_o = r_rdata;

   // ---------------------------------------------------------- load extract
   assign w_byte = ram_rdata_i[8*r_lo +: 8];
   assign w_half = ram_rdata_i[16*r_lo[1] +: 16];

   always_comb begin
      case (r_size)
         2'b00:   w_ldata = {{24{~r_uns & w_byte[7]}}, w_byte};
         2'b01:   w_ldata = {{16{~r_uns & w_half[15]}}, w_half};
         default: w_ldata = ram_rdata_i;
      endcase
   end

   // ----------------------------------------------------------- store merge
   // Replicating the store data across the word lets every lane pick its
   // own slice; the lane enable then decides which lanes take it.
   assign w_rep = (r_size == 2'b00) ? {4{r_wdata[7:0]}} : {2{r_wdata}};
   assign w_old = ram_rdata_i;
   assign w_new = w_rep;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_lwr[g] = (r_size == 2'b00) ? (r_lo == 2'(g))
                                          : (r_lo[1] == ((g / 2) == 1));
      mau_lane u_lane (
         .i_wr   (w_lwr[g]),
         .i_old  (w_old[g]),
         .i_new  (w_new[g]),
         .o_byte (w_mrg[g])
      );
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_lo    <= '0;
         r_size  <= '0;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_wdata <= '0;
         r_wword <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_acc) begin
         r_addr  <= req_addr_i[ADDR_WIDTH+1:2];
         r_lo    <= req_addr_i[1:0];
         r_size  <= req_size_i;
         r_we    <= req_we_i;
         r_uns   <= req_unsigned_i;
         r_wdata <= req_wdata_i[15:0];
         r_wword <= req_wdata_i;       // full word for SW, replaced for SB/SH
         r_rdata <= '0;                // stores and errors respond with 0
         r_err   <= w_misal;
      end else if (r_state == S_WAIT && ram_valid_i) begin
         if (r_we) r_wword <= w_mrg;
         else      r_rdata <= w_ldata;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic [9:0]  ram_addr_o;
   logic [31:0] ram_wdata_o, ram_rdata_i;
   logic        ram_read_en_o, ram_write_en_o, ram_valid_i;

   mem_access_unit #(.ADDR_WIDTH(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i),
      .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
      .ram_read_en_o(ram_read_en_o), .ram_write_en_o(ram_write_en_o),
      .ram_rdata_i(ram_rdata_i), .ram_valid_i(ram_valid_i)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // ------------------------------------------------------------ RAM model
   logic [31:0] mem [0:1023];
   int          extra_dly = 0;
   int          rd_cnt    = 0;
   logic [9:0]  rd_addr;

   always @(posedge clk) begin
      ram_valid_i <= 1'b0;
      if (ram_write_en_o) mem[ram_addr_o] <= ram_wdata_o;
      if (!rst_n) begin
         rd_cnt <= 0;
      end else if (ram_read_en_o) begin
         if (extra_dly == 0) begin
            ram_valid_i <= 1'b1;
            ram_rdata_i <= mem[ram_addr_o];
         end else begin
            rd_cnt  <= extra_dly;
            rd_addr <= ram_addr_o;
         end
      end else if (rd_cnt > 0) begin
         rd_cnt <= rd_cnt - 1;
         if (rd_cnt == 1) begin
            ram_valid_i <= 1'b1;
            ram_rdata_i <= mem[rd_addr];
         end
      end
   end

   // ----------------------------------------------------------- scoreboard
   typedef struct {
      int          acc;     // cyc value just after the accept edge
      logic [31:0] rdata;
      logic        err;
      int          lat;     // response cycle offset from accept (T+lat)
      int          rd;      // read strobe offset, -1 = none
      int          wr;      // write strobe offset, -1 = none
      logic [9:0]  waddr;
   } exp_t;

   exp_t q[$];
   int   obs_rd = -1;
   int   obs_wr = -1;
   int   off;

   always @(negedge clk) begin
      if (rst_n) begin
         if (q.size() == 0) begin
            if (rsp_valid_o || ram_write_en_o) begin
               tests++; fails++;
               $display("FAIL stray: rsp_valid=%0b write_en=%0b with nothing outstanding",
                        rsp_valid_o, ram_write_en_o);
            end
         end else begin
            off = cyc - q[0].acc + 1;
            if (ram_read_en_o) begin
               obs_rd = (obs_rd == -1) ? off : -2;
               chk("rd_addr", 32'(ram_addr_o), 32'(q[0].waddr));
            end
            if (ram_write_en_o) begin
               obs_wr = (obs_wr == -1) ? off : -2;
               chk("wr_addr", 32'(ram_addr_o), 32'(q[0].waddr));
            end
            if (rsp_valid_o) begin
               chk("rdata",   rsp_rdata_o,  q[0].rdata);
               chk("err",     32'(rsp_err_o), 32'(q[0].err));
               chk("latency", 32'(off),     32'(q[0].lat));
               chk("rd_slot", 32'(obs_rd),  32'(q[0].rd));
               chk("wr_slot", 32'(obs_wr),  32'(q[0].wr));
               void'(q.pop_front());
               obs_rd = -1;
               obs_wr = -1;
            end
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
      req_unsigned_i = uns; req_addr_i = a; req_wdata_i = d;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic start(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee,
                        input int lat, input int rd, input int wr);
      exp_t e;
      drive(we, sz, uns, a, d);
      e.acc = cyc; e.rdata = er; e.err = ee; e.lat = lat;
      e.rd = rd; e.wr = wr; e.waddr = a[11:2];
      q.push_back(e);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (q.size() == 0) break;
         @(negedge clk); #1;
      end
      if (q.size() != 0) begin
         tests++; fails++;
         $display("FAIL timeout: %0d responses outstanding, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee,
                     input int lat, input int rd, input int wr);
      start(we, sz, uns, a, d, er, ee, lat, rd, wr);
      wait_done();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      ram_rdata_i = '0; ram_valid_i = 1'b0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
      req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
      rst_n = 1'b0;
      #12;
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_rsp",   {29'd0, rsp_valid_o, rsp_err_o, ram_read_en_o}, 32'd0);
      chk("rst_wen",   32'(ram_write_en_o), 32'd0);
      chk("rst_rdata", rsp_rdata_o, 32'd0);
      chk("rst_addr",  32'(ram_addr_o), 32'd0);
      chk("rst_wdata", ram_wdata_o, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // SW then LW
      op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, -1, 1);
      chk("mem_sw", mem[4], 32'hDEADBEEF);
      op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, -1);

      // SB read-modify-write and byte loads
      op(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000080, 32'h0, 1'b0, 4, 1, 3);
      chk("mem_sb", mem[4], 32'hDEAD80EF);
      op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1, -1);
      op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0, 3, 1, -1);

      // SH and half loads
      op(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 4, 1, 3);
      chk("mem_sh", mem[4], 32'h123480EF);
      op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0, 3, 1, -1);
      op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF80EF, 1'b0, 3, 1, -1);
      op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h000080EF, 1'b0, 3, 1, -1);
      op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 3, 1, -1);
      op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000012, 1'b0, 3, 1, -1);
      // address wraps modulo RAM size
      op(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 32'h123480EF, 1'b0, 3, 1, -1);

      // misaligned / illegal
      op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, -1, -1);
      op(1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 32'h0, 1'b1, 1, -1, -1);
      op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, -1, -1);
      chk("mem_err", mem[4], 32'h123480EF);

      // delayed read data, requests while busy are ignored
      extra_dly = 5;
      start(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h123480EF, 1'b0, 8, 1, -1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10;
         req_addr_i = 32'h40; req_wdata_i = 32'hBAD0BAD0;
         #1 chk("busy_ready", 32'(req_ready_o), 32'd0);
      end
      @(negedge clk); req_valid_i = 1'b0;
      wait_done();
      chk("mem_busy", mem[16], 32'h0);

      // reset during WAIT of SB
      extra_dly = 3;
      drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
      chk("rst_mid_strb",  {30'd0, ram_write_en_o, rsp_valid_o}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("mem_rst", mem[4], 32'h123480EF);
      extra_dly = 0;
      op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h123480EF, 1'b0, 3, 1, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end
endmodule
